// File: rtl/skinny_sbox_layer_masked_pipe.sv
// Two-share Boolean-masked Skinny-64 S-box layer built from four NOR-XOR stages.
// PIPELINE=1 registers every stage; PIPELINE=0 reuses one stage over four cycles.
module skinny_sbox_layer_masked_pipe #(
  parameter int NUM_SBOX = 16,
  parameter int PIPELINE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*NUM_SBOX-1:0] in0,
  input  logic [4*NUM_SBOX-1:0] in1,
  input  logic [4*NUM_SBOX-1:0] r,
  output logic                  out_valid,
  output logic [4*NUM_SBOX-1:0] out0,
  output logic [4*NUM_SBOX-1:0] out1
);

  localparam int W = 4 * NUM_SBOX;

  typedef struct packed {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
  } shares_t;

  // Stage register content: untouched state shares plus the masked NOR term.
  typedef struct packed {
    shares_t             x;
    logic [NUM_SBOX-1:0] z0;
    logic [NUM_SBOX-1:0] z1;
  } stage_t;

  // Inversion of x3/x2 lives on share 0 only; cross terms are refreshed by rnd.
  function automatic stage_t masked_stage(input shares_t s, input logic [NUM_SBOX-1:0] rnd);
    stage_t st;
    logic   a0, b0, a1, b1;
    st.x  = s;
    st.z0 = '0;
    st.z1 = '0;
    for (int i = 0; i < NUM_SBOX; i++) begin
      a0 = ~s.x0[4*i+3];
      b0 = ~s.x0[4*i+2];
      a1 = s.x1[4*i+3];
      b1 = s.x1[4*i+2];
      st.z0[i] = (a0 & b0) ^ ((a0 & b1) ^ rnd[i]);
      st.z1[i] = (a1 & b1) ^ ((a1 & b0) ^ rnd[i]);
    end
    return st;
  endfunction

  function automatic shares_t finish_stage(input stage_t st, input logic rotate);
    shares_t    o;
    logic [3:0] n0, n1;
    o = st.x;
    for (int i = 0; i < NUM_SBOX; i++) begin
      n0 = st.x.x0[4*i +: 4];
      n1 = st.x.x1[4*i +: 4];
      n0[0] = n0[0] ^ st.z0[i];
      n1[0] = n1[0] ^ st.z1[i];
      if (rotate) begin
        n0 = {n0[2:0], n0[3]};
        n1 = {n1[2:0], n1[3]};
      end
      o.x0[4*i +: 4] = n0;
      o.x1[4*i +: 4] = n1;
    end
    return o;
  endfunction

  shares_t in_sh;
  shares_t out_sh;

  assign in_sh = {in0, in1};
  assign out0  = out_sh.x0;
  assign out1  = out_sh.x1;

  if (PIPELINE != 0) begin : g_pipe
    stage_t              stg_q [4];
    stage_t              stg_d [4];
    logic [3:0]          vld_q, vld_d;
    logic [NUM_SBOX-1:0] rnd [4];

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        rnd[k] = '0;
        for (int i = 0; i < NUM_SBOX; i++) rnd[k][i] = r[4*i+k];
      end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      vld_d = {vld_q[2:0], in_valid};
      stg_d = stg_q;
      if (in_valid) stg_d[0] = masked_stage(in_sh, rnd[0]);
      for (int k = 1; k < 4; k++) begin
        if (vld_q[k-1]) stg_d[k] = masked_stage(finish_stage(stg_q[k-1], 1'b1), rnd[k]);
      end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: stage registers are reset because the outputs must read zero after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < 4; k++) stg_q[k] <= '0;
      end else begin
        vld_q <= vld_d;
        stg_q <= stg_d;
      end
    end

    assign in_ready  = ~rst;
    assign out_valid = vld_q[3];
    assign out_sh    = finish_stage(stg_q[3], 1'b0);
  end else begin : g_iter
    typedef enum logic {IDLE, BUSY} state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    stage_t     stg_q, stg_d;
    logic       unused_r_hi;

    assign unused_r_hi = ^r[W-1:NUM_SBOX];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
        stg_q       <= '0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        out_valid_q <= out_valid_d;
        stg_q       <= stg_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      stg_d       = stg_q;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            stg_d   = masked_stage(in_sh, r[NUM_SBOX-1:0]);
            cnt_d   = 2'd1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          stg_d = masked_stage(finish_stage(stg_q, 1'b1), r[NUM_SBOX-1:0]);
          cnt_d = cnt_q + 2'd1;
          // cnt_q == 3 means stage 4 is written on this edge; cnt wraps to 0.
          if (cnt_q == 2'd3) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = out_valid_q;
      out_sh    = finish_stage(stg_q, 1'b0);
    end
  end

endmodule
